// File: rtl/reaction_ctrl_pkg.sv
// Shared constants for the reaction-time tester: display state codes and LFSR setup.
package reaction_ctrl_pkg;

  // Display state codes; these must match the LED matrix driver's decode.
  localparam logic [2:0] S0 = 3'b000;  // idle
  localparam logic [2:0] S1 = 3'b001;  // random wait
  localparam logic [2:0] S2 = 3'b010;  // fail
  localparam logic [2:0] S3 = 3'b011;  // go, waiting for reaction
  localparam logic [2:0] S4 = 3'b111;  // success

  typedef enum logic [2:0] {
    StIdle = S0,
    StWait = S1,
    StFail = S2,
    StGo   = S3,
    StDone = S4
  } state_e;

  // 16-bit Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Non-zero seed keeps the sequence out of the all-zero lock-up state.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_ctrl_ms_tick_gen.sv
// Millisecond tick generator: prescales clk down to 1 ms ticks and counts them.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned TIME_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              tick,
  output logic [TIME_W-1:0] ms_cnt
);

  localparam int unsigned   CntW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0]   tick_cnt_q;
  logic [TIME_W-1:0] ms_cnt_q;

  assign tick   = (tick_cnt_q == TickLast);
  assign ms_cnt = ms_cnt_q;

  // Prescaler and ms counter; clr restarts timing from zero on each state change.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick_cnt_q <= '0;
      ms_cnt_q   <= '0;
    end else begin
      if (tick) begin
        tick_cnt_q <= '0;
        ms_cnt_q   <= ms_cnt_q + TIME_W'(1);
      end else begin
        tick_cnt_q <= tick_cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random wait, reaction timing, false start,
// timeout and best-time tracking. Drives the LED driver's state code.
module reaction_ctrl
  import reaction_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter int unsigned TIMEOUT_MS   = 1000,
  parameter int unsigned HOLD_MS      = 3000,
  parameter int unsigned TIME_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic              react_btn,
  output logic [2:0]        state,
  output logic [TIME_W-1:0] react_ms,
  output logic              result_valid,
  output logic [TIME_W-1:0] best_ms,
  output logic              false_start
);

  localparam logic [TIME_W-1:0] TimeoutLast = TIME_W'(TIMEOUT_MS - 1);
  localparam logic [TIME_W-1:0] HoldLast    = TIME_W'(HOLD_MS - 1);
  localparam logic [TIME_W-1:0] MinDelay    = TIME_W'(MIN_DELAY_MS);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [TIME_W-1:0] delay_q;
  logic [TIME_W-1:0] react_ms_q;
  logic [TIME_W-1:0] best_ms_q;
  logic              result_valid_q;
  logic              false_start_q;

  logic              tick;
  logic [TIME_W-1:0] ms_cnt;
  logic              clr;
  logic              early_press;
  logic              hit;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TIME_W   (TIME_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .tick   (tick),
    .ms_cnt (ms_cnt)
  );

  // Next-state decode; earlier rules in each state take priority.
  always_comb begin
    state_d     = state_q;
    early_press = 1'b0;
    hit         = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_btn) state_d = StWait;
      end
      StWait: begin
        if (react_btn) begin
          state_d     = StFail;
          early_press = 1'b1;
        end else if (tick && (ms_cnt == delay_q - TIME_W'(1))) begin
          state_d = StGo;
        end
      end
      StGo: begin
        if (react_btn) begin
          state_d = StDone;
          hit     = 1'b1;
        end else if (tick && (ms_cnt == TimeoutLast)) begin
          state_d = StFail;
        end
      end
      StFail, StDone: begin
        if (start_btn) begin
          state_d = StWait;
        end else if (tick && (ms_cnt == HoldLast)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Every state change restarts the ms timebase.
  assign clr = (state_d != state_q);

  // FSM state, LFSR, wait latch and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      lfsr_q         <= LFSR_SEED;
      delay_q        <= '0;
      react_ms_q     <= '0;
      best_ms_q      <= '1;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_next(lfsr_q);
      result_valid_q <= hit;
      false_start_q  <= early_press;
      if (state_d == StWait && state_q != StWait) begin
        delay_q <= MinDelay + TIME_W'(lfsr_q[RAND_BITS-1:0]);
      end
      // ms_cnt here is the pre-increment value even if a tick lands this cycle.
      if (hit) begin
        react_ms_q <= ms_cnt;
        if (ms_cnt < best_ms_q) best_ms_q <= ms_cnt;
      end
    end
  end

  assign state        = state_q;
  assign react_ms     = react_ms_q;
  assign best_ms      = best_ms_q;
  assign result_valid = result_valid_q;
  assign false_start  = false_start_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with small timing parameters.
module tb_reaction_ctrl;

  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned MIN_DELAY_MS = 2;
  localparam int unsigned RAND_BITS    = 2;
  localparam int unsigned TIMEOUT_MS   = 8;
  localparam int unsigned HOLD_MS      = 5;
  localparam int unsigned TIME_W       = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       react_btn = 1'b0;
  logic [2:0] state;
  logic [7:0] react_ms;
  logic [7:0] best_ms;
  logic       result_valid;
  logic       false_start;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;

  reaction_ctrl #(
    .TICK_DIV     (TICK_DIV),
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .RAND_BITS    (RAND_BITS),
    .TIMEOUT_MS   (TIMEOUT_MS),
    .HOLD_MS      (HOLD_MS),
    .TIME_W       (TIME_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .state        (state),
    .react_ms     (react_ms),
    .result_valid (result_valid),
    .best_ms      (best_ms),
    .false_start  (false_start)
  );

  always #5 clk = ~clk;

  // Reference LFSR derived from x^16+x^14+x^13+x^11+1 (Galois, shift right).
  function automatic logic [15:0] model_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) begin
      r[15] = ~r[15];
      r[13] = ~r[13];
      r[12] = ~r[12];
      r[10] = ~r[10];
    end
    return r;
  endfunction

  always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : model_next(m_lfsr);

  // Count negedges until state equals s; -1 if it never does.
  task automatic wait_state(input logic [2:0] s, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (state === s) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", state); end
    checks++; if (react_ms !== 8'd0) begin errors++; $display("FAIL reset_react_ms: got %0d expected 0", react_ms); end
    checks++; if (best_ms !== 8'hFF) begin errors++; $display("FAIL reset_best_ms: got %h expected ff", best_ms); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL reset_false_start: got %b expected 0", false_start); end
  endtask

  // Start right after reset: seed ACE1 gives delay 3 ms = 12 cycles.
  task automatic test_first_wait();
    int n;
    rst = 1'b0;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL first_s1: got %b expected 001", state); end
    wait_state(3'b011, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL first_wait_len: got %0d expected 12", n); end
  endtask

  // React at ms_cnt=5 (tick_cnt=0), then check the one-cycle valid pulse.
  task automatic test_react();
    repeat (20) @(negedge clk);
    react_btn = 1'b1;
    @(negedge clk);
    react_btn = 1'b0;
    checks++; if (state !== 3'b111) begin errors++; $display("FAIL react_state: got %b expected 111", state); end
    checks++; if (react_ms !== 8'd5) begin errors++; $display("FAIL react_ms: got %0d expected 5", react_ms); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL react_valid: got %b expected 1", result_valid); end
    checks++; if (best_ms !== 8'd5) begin errors++; $display("FAIL react_best: got %0d expected 5", best_ms); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL react_valid_pulse: got %b expected 0", result_valid); end
  endtask

  // S4 held 20 cycles; one already consumed by the previous task.
  task automatic test_hold_idle();
    int n;
    wait_state(3'b000, n);
    checks++; if (n !== 19) begin errors++; $display("FAIL s4_hold: got %0d expected 19", n); end
  endtask

  // Second run reacting at ms_cnt=7 on the same cycle as a tick.
  task automatic test_second_run();
    int n;
    int exp_n;
    start_btn = 1'b1;
    exp_n = 4 * (2 + int'(m_lfsr[1:0]));
    @(negedge clk);
    start_btn = 1'b0;
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL second_s1: got %b expected 001", state); end
    wait_state(3'b011, n);
    checks++; if (n !== exp_n) begin errors++; $display("FAIL second_wait_len: got %0d expected %0d", n, exp_n); end
    repeat (31) @(negedge clk);
    react_btn = 1'b1;
    @(negedge clk);
    react_btn = 1'b0;
    checks++; if (state !== 3'b111) begin errors++; $display("FAIL second_state: got %b expected 111", state); end
    checks++; if (react_ms !== 8'd7) begin errors++; $display("FAIL second_react_ms: got %0d expected 7", react_ms); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL second_valid: got %b expected 1", result_valid); end
    checks++; if (best_ms !== 8'd5) begin errors++; $display("FAIL second_best: got %0d expected 5", best_ms); end
  endtask

  // Start at cycle 10 of S4 restarts straight into S1 with a fresh delay.
  task automatic test_restart_from_s4();
    int n;
    int exp_n;
    logic left_s4;
    left_s4 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (state !== 3'b111) left_s4 = 1'b1;
    end
    checks++; if (left_s4 !== 1'b0) begin errors++; $display("FAIL restart_left_s4: got %b expected 0", left_s4); end
    start_btn = 1'b1;
    exp_n = 4 * (2 + int'(m_lfsr[1:0]));
    @(negedge clk);
    start_btn = 1'b0;
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL restart_s1: got %b expected 001", state); end
    wait_state(3'b011, n);
    checks++; if (n !== exp_n) begin errors++; $display("FAIL restart_wait_len: got %0d expected %0d", n, exp_n); end
  endtask

  // No reaction: S3 times out after 32 cycles without a false_start pulse.
  task automatic test_timeout();
    int n;
    logic fs_seen;
    n = -1;
    fs_seen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (false_start === 1'b1) fs_seen = 1'b1;
      if (state === 3'b010) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL timeout_len: got %0d expected 32", n); end
    checks++; if (fs_seen !== 1'b0) begin errors++; $display("FAIL timeout_false_start: got %b expected 0", fs_seen); end
    wait_state(3'b000, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL s2_hold: got %0d expected 20", n); end
  endtask

  // Early press in S1 goes to S2 with a one-cycle false_start pulse.
  task automatic test_false_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL fs_s1: got %b expected 001", state); end
    repeat (3) @(negedge clk);
    react_btn = 1'b1;
    @(negedge clk);
    react_btn = 1'b0;
    checks++; if (state !== 3'b010) begin errors++; $display("FAIL fs_state: got %b expected 010", state); end
    checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fs_pulse: got %b expected 1", false_start); end
    checks++; if (react_ms !== 8'd7) begin errors++; $display("FAIL fs_react_ms: got %0d expected 7", react_ms); end
    checks++; if (best_ms !== 8'd5) begin errors++; $display("FAIL fs_best: got %0d expected 5", best_ms); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL fs_valid: got %b expected 0", result_valid); end
    @(negedge clk);
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL fs_pulse_len: got %b expected 0", false_start); end
  endtask

  // Reset mid-S3 clears everything; react in S0 is then ignored.
  task automatic test_reset_mid_s3();
    int n;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL rst_s1: got %b expected 001", state); end
    wait_state(3'b011, n);
    checks++; if (n <= 0) begin errors++; $display("FAIL rst_reach_s3: got %0d expected >0", n); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL rst_state: got %b expected 000", state); end
    checks++; if (best_ms !== 8'hFF) begin errors++; $display("FAIL rst_best: got %h expected ff", best_ms); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", result_valid); end
    checks++; if (react_ms !== 8'd0) begin errors++; $display("FAIL rst_react_ms: got %0d expected 0", react_ms); end
    react_btn = 1'b1;
    @(negedge clk);
    react_btn = 1'b0;
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL idle_react_state: got %b expected 000", state); end
    @(negedge clk);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL idle_react_valid: got %b expected 0", result_valid); end
    checks++; if (react_ms !== 8'd0) begin errors++; $display("FAIL idle_react_ms: got %0d expected 0", react_ms); end
    checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL idle_react_fs: got %b expected 0", false_start); end
  endtask

  initial begin
    test_reset();
    test_first_wait();
    test_react();
    test_hold_idle();
    test_second_run();
    test_restart_from_s4();
    test_timeout();
    test_false_start();
    test_reset_mid_s3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
